// File: rtl/adc_spi_pkg.sv
// Shared types and default sizing for the ADC-emulating SPI responder.
package adc_spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_FRAME_W     = 16;
  localparam int DEF_CMD_W       = 6;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int CNT_W           = $clog2(DEF_FRAME_W + 1);

  function automatic int cnt_w(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection.
module spi_pin_sync
  import adc_spi_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // Top element holds the previous synchronized level for edge detection.
  logic [SYNC_STAGES:0] sync_q;
  // Edges are reported only once real pin samples have reached the compare
  // point, so a pin already low at reset release never reads as a fall.
  logic [SYNC_STAGES:0] vld_pipe;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q   <= {(SYNC_STAGES+1){RST_VAL}};
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-1:0], pin};
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = vld_pipe[SYNC_STAGES] &&  level && !sync_q[SYNC_STAGES];
  assign fall  = vld_pipe[SYNC_STAGES] && !level &&  sync_q[SYNC_STAGES];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-0 slave standing in for the ADC: captures a command from MOSI and
// shifts a held sample out on MISO each frame, all in the system clock domain.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int CMD_W       = DEF_CMD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk_0_clk,
  input  logic              reset_0_reset_n,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_valid,
  output logic              frame_err,
  output logic              underrun
);

  localparam int CW       = cnt_w(FRAME_W);
  localparam int PAD      = FRAME_W - DATA_W;
  localparam int NUM_PINS = 3;
  localparam int P_SCLK   = 0;
  localparam int P_SS     = 1;
  localparam int P_MOSI   = 2;

  logic [NUM_PINS-1:0] pin_raw, pin_lvl, pin_rise, pin_fall;

  assign pin_raw = {spi_mosi, spi_ss_n, spi_sclk};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
    spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (i == P_SS)
    ) u_sync (
      .gclk   (clk_0_clk),
      .grst_n (reset_0_reset_n),
      .pin    (pin_raw[i]),
      .level  (pin_lvl[i]),
      .rise   (pin_rise[i]),
      .fall   (pin_fall[i])
    );
  end

  logic unused_pins;
  assign unused_pins = pin_lvl[P_SCLK] ^ pin_rise[P_MOSI] ^ pin_fall[P_MOSI];

  logic ss_lvl, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_lvl;
  assign ss_lvl    = pin_lvl[P_SS];
  assign ss_rise   = pin_rise[P_SS];
  assign ss_fall   = pin_fall[P_SS];
  assign sclk_rise = pin_rise[P_SCLK];
  assign sclk_fall = pin_fall[P_SCLK];
  assign mosi_lvl  = pin_lvl[P_MOSI];

  state_e             state, state_nxt;
  logic [CW-1:0]      bit_cnt, cnt_nxt;
  logic               frame_start, frame_end, abort, accept;
  logic               rdy_en, hold_full;
  logic [DATA_W-1:0]  hold, last_sample, src;
  logic [FRAME_W-1:0] shift_out, shift_in, shift_in_nxt;

  always_ff @(posedge clk_0_clk or negedge reset_0_reset_n) begin
    if (!reset_0_reset_n) state <= IDLE;
    else                  state <= state_nxt;
  end

  // A final SCLK rise coinciding with SS_n rising still completes the frame.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    abort       = 1'b0;
    cnt_nxt     = bit_cnt + CW'(sclk_rise);
    case (state)
      IDLE: if (ss_fall) begin
        state_nxt   = SHIFT;
        frame_start = 1'b1;
      end
      SHIFT: begin
        if (sclk_rise && bit_cnt == CW'(FRAME_W - 1)) begin
          frame_end = 1'b1;
          state_nxt = ss_rise ? IDLE : DONE;
        end else if (ss_rise) begin
          state_nxt = IDLE;
          abort     = (cnt_nxt != '0);
        end
      end
      DONE:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame source priority: held sample, then same-cycle bypass, then resend.
  assign src          = hold_full ? hold : (sample_valid ? sample_data : last_sample);
  assign accept       = sample_valid && sample_ready && !frame_start;
  assign shift_in_nxt = {shift_in[FRAME_W-2:0], mosi_lvl};
  assign sample_ready = rdy_en && !hold_full;

  always_ff @(posedge clk_0_clk or negedge reset_0_reset_n) begin
    if (!reset_0_reset_n) begin
      rdy_en      <= 1'b0;
      hold_full   <= 1'b0;
      hold        <= '0;
      last_sample <= '0;
      shift_out   <= '0;
      shift_in    <= '0;
      bit_cnt     <= '0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      frame_err   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      cmd_valid <= frame_end;
      frame_err <= abort;
      underrun  <= frame_start && !hold_full && !sample_valid;

      if (accept) begin
        hold      <= sample_data;
        hold_full <= 1'b1;
      end else if (frame_start) begin
        hold_full <= 1'b0;
      end

      if (frame_start) begin
        shift_out   <= FRAME_W'(src) << PAD;
        last_sample <= src;
        bit_cnt     <= '0;
      end else if (state == SHIFT) begin
        if (sclk_rise) begin
          shift_in <= shift_in_nxt;
          bit_cnt  <= cnt_nxt;
        end
        if (sclk_fall && bit_cnt != '0) shift_out <= shift_out << 1;
      end

      if (frame_end) cmd_data <= shift_in_nxt[FRAME_W-1 -: CMD_W];
      if (state != IDLE && state_nxt == IDLE) bit_cnt <= '0;
    end
  end

  assign spi_miso_oe = !ss_lvl;
  assign spi_miso    = spi_miso_oe && (state == SHIFT) && shift_out[FRAME_W-1];

endmodule
